// File: rtl/clock_ctrl_pkg.sv
// Shared types and constants for the run/halt/single-step clock controller.
// Holds the controller state encoding and the divider-tap width.
package clock_ctrl_pkg;

    localparam int CLK_SEL_W = 3;

    typedef enum logic [2:0] {
        ST_STOPPED   = 3'd0,
        ST_RUN       = 3'd1,
        ST_HALT_PEND = 3'd2,
        ST_STEP_FALL = 3'd3,
        ST_STEP_RISE = 3'd4
    } clock_ctrl_state_t;

    function automatic logic is_rise(input logic prev, input logic cur);
        return !prev && cur;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Panel button conditioner: 2-flop synchroniser, optional debouncer, registered rise pulse.
// The debouncer is built only when CLOCK_CTRL_DEBOUNCE_EN is defined.
module btn_debounce
    import clock_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 5000
) (
    input  logic clk,
    input  logic arst,
    input  logic btn_raw,
    output logic btn_pulse
);

    logic sync1_q;
    logic sync2_q;
    logic level;
    logic level_prev_q;
    logic pulse_q;
    logic pulse_d;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

`ifdef CLOCK_CTRL_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             db_q;
    logic             db_d;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            cnt_q <= '0;
            db_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            db_q  <= db_d;
        end
    end

    assign level = db_q;
`else
    // The debounce length has no meaning when the debouncer is left out.
    localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;

    assign level = sync2_q;
`endif

    assign pulse_d = is_rise(level_prev_q, level);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            level_prev_q <= 1'b0;
            pulse_q      <= 1'b0;
        end else begin
            level_prev_q <= level;
            pulse_q      <= pulse_d;
        end
    end

    assign btn_pulse = pulse_q;

endmodule

// File: rtl/clock_ctrl.sv
// Run/halt/single-step controller driving the clock generator's stop_clk and clk_sel.
// Button debouncing depends on CLOCK_CTRL_DEBOUNCE_EN (see btn_debounce).
module clock_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 5000,
    parameter bit START_RUNNING   = 1'b0
) (
    input  logic                 clk,
    input  logic                 arst,
    input  logic                 run_btn,
    input  logic                 halt_btn,
    input  logic                 step_btn,
    input  logic                 cpu_halt,
    input  logic [CLK_SEL_W-1:0] speed_sel,
    input  logic                 clk_out,
    output logic                 stop_clk,
    output logic [CLK_SEL_W-1:0] clk_sel,
    output logic                 running,
    output logic                 step_busy,
    output logic                 step_done
);

    localparam clock_ctrl_state_t RESET_STATE = START_RUNNING ? ST_RUN : ST_STOPPED;

    logic run_pulse;
    logic halt_pulse;
    logic step_pulse;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_btn (
        .clk(clk), .arst(arst), .btn_raw(run_btn), .btn_pulse(run_pulse)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_halt_btn (
        .clk(clk), .arst(arst), .btn_raw(halt_btn), .btn_pulse(halt_pulse)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_btn (
        .clk(clk), .arst(arst), .btn_raw(step_btn), .btn_pulse(step_pulse)
    );

    clock_ctrl_state_t    state_q;
    clock_ctrl_state_t    state_d;
    logic                 stop_clk_q;
    logic                 stop_clk_d;
    logic [CLK_SEL_W-1:0] clk_sel_q;
    logic [CLK_SEL_W-1:0] clk_sel_d;
    logic                 step_done_q;
    logic                 step_done_d;
    logic                 co_q;
    logic                 cpu_halt_q;
    logic                 cpu_halt_prev_q;
    logic                 cpu_halt_pulse;
    logic                 co_rise;

    assign cpu_halt_pulse = cpu_halt_q & ~cpu_halt_prev_q;
    assign co_rise        = is_rise(co_q, clk_out);

    always_comb begin
        state_d     = state_q;
        clk_sel_d   = clk_sel_q;
        step_done_d = 1'b0;
        unique case (state_q)
            ST_STOPPED: begin
                // The divider tap only moves while the generator is frozen.
                clk_sel_d = speed_sel;
                if (!halt_pulse) begin
                    if (step_pulse) begin
                        state_d = ST_STEP_FALL;
                    end else if (run_pulse) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (halt_pulse || cpu_halt_pulse) begin
                    state_d = ST_HALT_PEND;
                end
            end
            ST_HALT_PEND: begin
                if (co_rise) begin
                    state_d = ST_STOPPED;
                end
            end
            ST_STEP_FALL: begin
                if (!clk_out) begin
                    state_d = ST_STEP_RISE;
                end
            end
            ST_STEP_RISE: begin
                if (co_rise) begin
                    state_d     = ST_STOPPED;
                    step_done_d = 1'b1;
                end
            end
            default: state_d = ST_STOPPED;
        endcase
        // Raising stop_clk on the edge that sees the rise freezes the counter before the next fall.
        stop_clk_d = (state_d == ST_STOPPED);
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q         <= RESET_STATE;
            stop_clk_q      <= !START_RUNNING;
            clk_sel_q       <= '0;
            step_done_q     <= 1'b0;
            co_q            <= 1'b0;
            cpu_halt_q      <= 1'b0;
            cpu_halt_prev_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            stop_clk_q      <= stop_clk_d;
            clk_sel_q       <= clk_sel_d;
            step_done_q     <= step_done_d;
            co_q            <= clk_out;
            cpu_halt_q      <= cpu_halt;
            cpu_halt_prev_q <= cpu_halt_q;
        end
    end

    assign stop_clk  = stop_clk_q;
    assign clk_sel   = clk_sel_q;
    assign step_done = step_done_q;
    assign running   = (state_q == ST_RUN) || (state_q == ST_HALT_PEND);
    assign step_busy = (state_q == ST_STEP_FALL) || (state_q == ST_STEP_RISE);

endmodule

// File: tb/tb_clock_ctrl.sv
// Directed bench for clock_ctrl with a behavioural clock generator attached.
// Expected button latencies follow CLOCK_CTRL_DEBOUNCE_EN as seen by this file.
module tb_clock_ctrl;
    import clock_ctrl_pkg::*;

    localparam int DB = 4;
`ifdef CLOCK_CTRL_DEBOUNCE_EN
    localparam int LAT         = DB + 3;
    localparam int BOUNCE_TICK = LAT + 4;
`else
    localparam int LAT         = 3;
    localparam int BOUNCE_TICK = LAT + 1;
`endif

    logic                 clk = 1'b0;
    logic                 arst;
    logic                 run_btn;
    logic                 halt_btn;
    logic                 step_btn;
    logic                 cpu_halt;
    logic [CLK_SEL_W-1:0] speed_sel;
    logic                 clk_out;
    logic                 stop_clk;
    logic [CLK_SEL_W-1:0] clk_sel;
    logic                 running;
    logic                 step_busy;
    logic                 step_done;
    logic [7:0]           gen_cnt;

    int checks = 0;
    int errors = 0;

    clock_ctrl #(.DEBOUNCE_CYCLES(DB), .START_RUNNING(1'b0)) dut (
        .clk(clk), .arst(arst), .run_btn(run_btn), .halt_btn(halt_btn),
        .step_btn(step_btn), .cpu_halt(cpu_halt), .speed_sel(speed_sel),
        .clk_out(clk_out), .stop_clk(stop_clk), .clk_sel(clk_sel),
        .running(running), .step_busy(step_busy), .step_done(step_done)
    );

    always #5 clk = ~clk;

    // Generator model: counter advances on the falling edge unless stop_clk is high.
    always @(negedge clk or posedge arst) begin
        if (arst) gen_cnt <= 8'd0;
        else if (!stop_clk) gen_cnt <= gen_cnt + 8'd1;
    end
    assign clk_out = gen_cnt[clk_sel];

    typedef struct {
        logic [2:0] speed_sel;
        logic       exp_stop;
        logic [2:0] exp_clk_sel;
        logic       exp_running;
        logic       exp_busy;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic expect_stop(input string name, input int arm);
        logic prev;
        bit   done = 1'b0;
        ticks(arm);
        check({name, " pending stop_clk"}, stop_clk, 0);
        prev = clk_out;
        for (int i = 0; i < 64 && !done; i++) begin
            tick();
            if (stop_clk || (!prev && clk_out)) begin
                done = 1'b1;
                check({name, " stop_clk at rise"}, stop_clk, 1);
                check({name, " clk_out prev/now"}, {prev, clk_out}, 2'b01);
            end
            prev = clk_out;
        end
        if (!done) check({name, " stop timeout"}, stop_clk, 1);
        check({name, " running after stop"}, running, 0);
    endtask

    task automatic do_step(input string name, input bit with_run, input bit check_edges);
        int         falls = 0;
        int         rises = 0;
        int         dones = 0;
        bit         ran   = 1'b0;
        logic       prev;
        logic [7:0] c0;
        logic [7:0] delta;
        c0       = gen_cnt;
        prev     = clk_out;
        step_btn = 1'b1;
        run_btn  = with_run;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (i == 9) begin
                step_btn = 1'b0;
                run_btn  = 1'b0;
            end
            if (prev && !clk_out) falls++;
            if (!prev && clk_out) rises++;
            if (step_done) dones++;
            if (running) ran = 1'b1;
            prev = clk_out;
        end
        delta = gen_cnt - c0;
        check({name, " step_done pulses"}, dones, 1);
        check({name, " stop_clk at end"}, stop_clk, 1);
        check({name, " step_busy at end"}, step_busy, 0);
        if (with_run) check({name, " run ignored"}, ran, 0);
        if (check_edges) begin
            check({name, " clk_out falls"}, falls, 1);
            check({name, " clk_out rises"}, rises, 1);
            check({name, " counter advance"}, delta, 2);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [7:0] frozen;
        int         first;
        bit         seen;

        vecs[0] = '{speed_sel: 3'd2, exp_stop: 1'b1, exp_clk_sel: 3'd2, exp_running: 1'b0, exp_busy: 1'b0};
        vecs[1] = '{speed_sel: 3'd5, exp_stop: 1'b1, exp_clk_sel: 3'd5, exp_running: 1'b0, exp_busy: 1'b0};
        vecs[2] = '{speed_sel: 3'd7, exp_stop: 1'b1, exp_clk_sel: 3'd7, exp_running: 1'b0, exp_busy: 1'b0};
        vecs[3] = '{speed_sel: 3'd0, exp_stop: 1'b1, exp_clk_sel: 3'd0, exp_running: 1'b0, exp_busy: 1'b0};
        vecs[4] = '{speed_sel: 3'd2, exp_stop: 1'b1, exp_clk_sel: 3'd2, exp_running: 1'b0, exp_busy: 1'b0};

        arst = 1'b1; run_btn = 1'b0; halt_btn = 1'b0; step_btn = 1'b0;
        cpu_halt = 1'b0; speed_sel = 3'd2;
        ticks(2);
        check("reset stop_clk", stop_clk, 1);
        check("reset clk_sel", clk_sel, 0);
        check("reset running", running, 0);
        check("reset step_busy", step_busy, 0);
        check("reset step_done", step_done, 0);
        arst = 1'b0;

        // STOPPED: clk_sel follows speed_sel one cycle later
        for (int i = 0; i < 5; i++) begin
            speed_sel = vecs[i].speed_sel;
            tick();
            check($sformatf("vec%0d stop_clk", i), stop_clk, vecs[i].exp_stop);
            check($sformatf("vec%0d clk_sel", i), clk_sel, vecs[i].exp_clk_sel);
            check($sformatf("vec%0d running", i), running, vecs[i].exp_running);
            check($sformatf("vec%0d step_busy", i), step_busy, vecs[i].exp_busy);
        end

        // Run press held 10 cycles
        run_btn = 1'b1;
        ticks(LAT);
        check("run latency before", running, 0);
        tick();
        check("run latency at", running, 1);
        check("run stop_clk", stop_clk, 0);
        ticks(10 - LAT - 1);
        run_btn = 1'b0;
        ticks(12);

        // Halt press: stop lands on the next clk_out rise
        halt_btn = 1'b1;
        expect_stop("halt_btn", LAT + 1);
        frozen = gen_cnt;
        ticks(4);
        check("halt counter frozen", gen_cnt, frozen);
        check("halt clk_out high", clk_out, 1);
        halt_btn = 1'b0;
        ticks(10);

        // Steps at tap 0; the first also carries a simultaneous run press
        speed_sel = 3'd0;
        tick();
        check("step clk_sel", clk_sel, 0);
        do_step("step+run", 1'b1, 1'b0);
        do_step("step1", 1'b0, 1'b1);
        do_step("step2", 1'b0, 1'b1);
        do_step("step3", 1'b0, 1'b1);

        // Halt and step together in STOPPED: nothing happens
        frozen   = gen_cnt;
        seen     = 1'b0;
        halt_btn = 1'b1;
        step_btn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 9) begin
                halt_btn = 1'b0;
                step_btn = 1'b0;
            end
            if (step_busy || running) seen = 1'b1;
        end
        check("halt+step no action", seen, 0);
        check("halt+step counter", gen_cnt, frozen);

        // Bounced run button at tap 3
        speed_sel = 3'd3;
        tick();
        first = 0;
        for (int k = 0; k < 24; k++) begin
            run_btn = (k != 2) && (k < 16);
            tick();
            if (running && first == 0) first = k + 1;
        end
        check("bounce run tick", first, BOUNCE_TICK);

        // speed_sel is ignored while running; cpu_halt stops at the next rise
        speed_sel = 3'd6;
        ticks(5);
        check("run clk_sel held", clk_sel, 3);
        cpu_halt = 1'b1;
        expect_stop("cpu_halt", 2);
        check("cpu_halt clk_sel at stop", clk_sel, 3);
        frozen = gen_cnt;
        tick();
        check("stopped clk_sel update", clk_sel, 6);
        ticks(3);
        check("cpu_halt counter frozen", gen_cnt, frozen);
        cpu_halt = 1'b0;

        // Reset in STEP_RISE at tap 2
        speed_sel = 3'd2;
        tick();
        step_btn = 1'b1;
        seen     = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            tick();
            if (step_busy && !clk_out) seen = 1'b1;
        end
        check("step fall reached", seen, 1);
        tick();
        check("step rise busy", step_busy, 1);
        arst = 1'b1;
        #1;
        check("arst stop_clk", stop_clk, 1);
        check("arst step_busy", step_busy, 0);
        check("arst clk_sel", clk_sel, 0);
        check("arst running", running, 0);
        check("arst step_done", step_done, 0);
        step_btn = 1'b0;
        seen     = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) arst = 1'b0;
            tick();
            if (step_done) seen = 1'b1;
        end
        check("no step_done after arst", seen, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clock_ctrl.md
# clock_ctrl

Run/halt/single-step controller directly upstream of the system clock generator. Runs on the generator's base clock, turns front-panel buttons and the CPU halt request into the generator's `stop_clk` and `clk_sel` inputs, and watches the generator's `clk_out` so that every stop lands with `clk_out` high. A single step passes exactly one full `clk_out` period: a fall followed by a rise.

## Interface
- `DEBOUNCE_CYCLES`, 5000: stable cycles needed before a button level is accepted (10 ms at 500 kHz).
- `START_RUNNING`, 0: when 1, the block leaves reset in RUN instead of STOPPED.
- `clk` in 1: base clock, the same net that feeds the generator. All logic is on the rising edge.
- `arst` in 1: asynchronous, active-high reset.
- `run_btn`, `halt_btn`, `step_btn` in 1 each: raw panel buttons, asynchronous, active-high.
- `cpu_halt` in 1: halt request from the CPU, synchronous to `clk`. Rising-edge sensitive.
- `speed_sel` in 3: requested divider tap.
- `clk_out` in 1: feedback from the generator output.
- `stop_clk` out 1: freezes the generator counter.
- `clk_sel` out 3: divider tap sent to the generator.
- `running` out 1: high in RUN and HALT_PEND.
- `step_busy` out 1: high in STEP_FALL and STEP_RISE.
- `step_done` out 1: one-cycle pulse when a step completes.

## Operation
- Buttons: each passes through a 2-flop synchroniser, then a debouncer, then a rising-edge detect that produces a 1-cycle pulse.
- `cpu_halt`: registered once and edge-detected into a 1-cycle pulse.
- `clk_out`: registered as `co_q`. A rise is `co_q==0 && clk_out==1`.
- States: STOPPED, RUN, HALT_PEND, STEP_FALL, STEP_RISE.
- STOPPED:
  - run pulse → RUN.
  - step pulse → STEP_FALL.
  - `clk_sel <= speed_sel` every cycle. `clk_sel` never changes in any other state, so no divider glitch can occur.
- RUN: halt pulse or cpu_halt pulse → HALT_PEND.
- HALT_PEND: on a `clk_out` rise → STOPPED.
- STEP_FALL: when `clk_out==0` (level) → STEP_RISE. This state passes in one cycle if `clk_out` is already low.
- STEP_RISE: on a `clk_out` rise → STOPPED, with `step_done` pulsed for 1 cycle.
- Halt pulse in STEP_FALL or STEP_RISE: the step is still completed and its end is the stop point. No extra action.
- Run and step pulses outside STOPPED are ignored.
- Simultaneous pulses in STOPPED: priority is halt (no-op) > step > run.
- `stop_clk` is registered:
  - 0 in RUN, HALT_PEND, STEP_FALL, STEP_RISE.
  - Set to 1 in the same cycle as the transition into STOPPED.

## Timing
- Reset values:
  - `START_RUNNING=0`: state STOPPED, `stop_clk=1`, `running=0`.
  - `START_RUNNING=1`: state RUN, `stop_clk=0`, `running=1`.
  - Always: `clk_sel=0`, `step_busy=0`, `step_done=0`, all synchronisers and debouncers 0.
- Reset mid-step or mid-halt aborts immediately to the reset values.
- Why stops are exact: the generator samples `stop_clk` on the falling edge. A rise seen at rising edge t sets `stop_clk=1` at t, so the counter does not advance at t+½. The stop leaves `clk_out==1`.
- Step or run latency: the pulse at rising edge t drives `stop_clk` low after t, and the generator counter first advances at t+½.
- Debounce:
  - Counter width `$clog2(DEBOUNCE_CYCLES+1)`.
  - The debounced level flips after the synchronised input differs from it for DEBOUNCE_CYCLES consecutive cycles.
  - A glitch resets the count.
- Button latency: the pulse occurs DEBOUNCE_CYCLES+3 cycles after the raw button is first sampled high, given a stable press.
- `cpu_halt` latency: pulse 1 cycle after assertion; HALT_PEND entered on the following edge.

## Configuration
- `CLOCK_CTRL_DEBOUNCE_EN` defined: the debouncer is built as described above.
- Undefined:
  - The debouncer is omitted and `DEBOUNCE_CYCLES` is unused.
  - The pulse follows the synchroniser plus edge detect.
  - Button latency is 3 cycles.
  - Intended for simulation benches.

## Structure
- Package `clock_ctrl_pkg`: holds the state enum `clock_ctrl_state_t` and the width constant `CLK_SEL_W = 3`.
- Sub-module `btn_debounce`:
  - Contains the synchroniser, debouncer (macro-guarded) and rise pulse.
  - Parameter `DEBOUNCE_CYCLES`; ports `clk`, `arst`, `btn_raw`, `btn_pulse`.
  - Instantiated three times.

## Test plan
Bench uses `DEBOUNCE_CYCLES=4` with the macro defined, with the clock generator model attached.
- Reset, then `speed_sel=2`: `stop_clk=1`, `clk_sel` reads 2 after 1 cycle, `running=0`.
- Run press held 10 cycles, then halt press mid-run: `running` rises 7 cycles after press sampled. Stop occurs on the next `clk_out` rise. Generator counter frozen with `clk_out==1`.
- Three step presses, `clk_sel=0`: each yields exactly one `clk_out` fall and one rise and one `step_done` pulse. Counter advances by 2 per step.
- Bounced run button (2-cycle high, 1 low, 2 high, then stable): a single run pulse, issued only after 4 stable cycles.
- `cpu_halt` rises in RUN with `clk_sel=3`: HALT_PEND entered, stop occurs at the next `clk_out` rise. `speed_sel` changes during RUN have no effect on `clk_sel` until STOPPED.
- `arst` during STEP_RISE: `stop_clk=1`, `step_busy=0`, `clk_sel=0` immediately. No `step_done` pulse.
